// File: rtl/ram_dp_bist.sv
// ram_dp_bist: built-in self test around an inferred simple dual-port RAM.
// A run writes a pattern to every address, reads every address back, compares
// each word against the same pattern and reports the mismatch count, the
// first failing address and a pass flag.
//
// Ports:
//   sys_clk        - single clock for all logic
//   sys_rst        - asynchronous, active-high reset (RAM contents are not reset)
//   start          - starts one run when the block is idle
//   mode[1:0]      - pattern select, sampled with start
//   inject_err     - corrupts bit 0 of the word written to address 3, sampled with start
//   busy           - high while writing, reading or draining
//   done           - one-cycle pulse at the end of a run
//   pass           - last run found zero mismatches
//   err_cnt        - mismatch count of the last run (saturates at depth)
//   first_err_addr - address of the first mismatch of the last run
module ram_dp_bist #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   ERR_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_INJ = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                inj_q, inj_d;

  logic                we_c;
  logic [DATA_W-1:0]   wdata_c;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_q;

  // Compare pipeline: stage 1 aligns with the RAM output, stage 2 for READ_LAT=2
  logic                v1_q, v2_q;
  logic [ADDR_W-1:0]   a1_q, a2_q;
  logic [DATA_W-1:0]   d2_q;

  logic                cmp_v_c;
  logic [ADDR_W-1:0]   cmp_a_c;
  logic [DATA_W-1:0]   cmp_d_c;
  logic                mismatch_c;

  logic                busy_d, done_d, pass_d;
  logic [ADDR_W:0]     err_d;
  logic [ADDR_W-1:0]   fea_d;

  // Expected data word for address a under pattern mode m
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      2'd0:    p = DATA_W'(a);
      2'd1:    p = ~DATA_W'(a);
      2'd2:    for (int i = 0; i < int'(DATA_W); i++) p[i] = ~(i[0] ^ a[0]);
      default: p = '1;
    endcase
    return p;
  endfunction

  // RAM: write port A and registered read port B share the run address counter
  always_ff @(posedge sys_clk) begin
    if (we_c) mem[cnt_q] <= wdata_c;
    rd_q <= mem[cnt_q];
  end

  assign cmp_v_c    = (READ_LAT == 2) ? v2_q : v1_q;
  assign cmp_a_c    = (READ_LAT == 2) ? a2_q : a1_q;
  assign cmp_d_c    = (READ_LAT == 2) ? d2_q : rd_q;
  assign mismatch_c = cmp_v_c && (cmp_d_c != pattern(mode_q, cmp_a_c));

  // Next state, counters and result registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    inj_d   = inj_q;
    we_c    = 1'b0;
    wdata_c = pattern(mode_q, cnt_q);
    err_d   = err_cnt;
    fea_d   = first_err_addr;
    pass_d  = pass;

    if (inj_q && (cnt_q == ADDR_INJ)) wdata_c[0] = ~wdata_c[0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
          mode_d  = mode;
          inj_d   = inject_err;
        end
      end
      WRITE: begin
        we_c  = 1'b1;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = READ;
      end
      READ: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && start) begin
      err_d  = '0;
      fea_d  = '0;
      pass_d = 1'b0;
    end else if (mismatch_c) begin
      if (err_cnt == '0) fea_d = cmp_a_c;
      if (err_cnt != ERR_MAX) err_d = err_cnt + (ADDR_W+1)'(1);
    end

    // The last compare lands on the edge into DONE, so pass uses the updated count
    if (state_q != DONE && state_d == DONE) pass_d = (err_d == '0);

    busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State, control and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mode_q         <= '0;
      inj_q          <= 1'b0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      a1_q           <= '0;
      a2_q           <= '0;
      d2_q           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      inj_q          <= inj_d;
      v1_q           <= (state_q == READ);
      a1_q           <= cnt_q;
      v2_q           <= v1_q;
      a2_q           <= a1_q;
      d2_q           <= rd_q;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_cnt        <= err_d;
      first_err_addr <= fea_d;
    end
  end

endmodule

// File: tb/tb_ram_dp_bist.sv
// Directed bench for ram_dp_bist: two instances (READ_LAT=1 and READ_LAT=2)
// share clock and stimulus; each run records busy length and done timing.
module tb_ram_dp_bist;

  logic       sys_clk;
  logic       sys_rst;
  logic       start;
  logic [1:0] mode;
  logic       inject_err;

  logic       busy_a, done_a, pass_a;
  logic [5:0] err_cnt_a;
  logic [4:0] fea_a;
  logic       busy_b, done_b, pass_b;
  logic [5:0] err_cnt_b;
  logic [4:0] fea_b;

  int vectors;
  int miscompares;

  int dc_a, dn_a, bn_a, clr_a;
  int dc_b, dn_b, bn_b, clr_b;

  ram_dp_bist #(.DATA_W(8), .ADDR_W(5), .READ_LAT(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .inject_err(inject_err), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_cnt_a), .first_err_addr(fea_a)
  );

  ram_dp_bist #(.DATA_W(8), .ADDR_W(5), .READ_LAT(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .inject_err(inject_err), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .first_err_addr(fea_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One run: start edge is cycle 0, sample i reflects cycle i after it.
  // pulse_at re-asserts start for one cycle; rst_at asserts reset for two cycles.
  task automatic run(input logic [1:0] m, input logic inj, input int pulse_at, input int rst_at);
    dc_a = -1; dn_a = 0; bn_a = 0; clr_a = -1;
    dc_b = -1; dn_b = 0; bn_b = 0; clr_b = -1;
    mode = m;
    inject_err = inj;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 1) begin
        clr_a = int'(err_cnt_a);
        clr_b = int'(err_cnt_b);
      end
      if (busy_a) bn_a++;
      if (busy_b) bn_b++;
      if (done_a) begin dn_a++; if (dc_a < 0) dc_a = i; end
      if (done_b) begin dn_b++; if (dc_b < 0) dc_b = i; end
      start = (i == pulse_at);
      if (i == rst_at) sys_rst = 1'b1;
      if (rst_at != 0 && i == rst_at + 2) sys_rst = 1'b0;
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sys_rst     = 1'b1;
    start       = 1'b0;
    mode        = 2'd0;
    inject_err  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err_cnt", err_cnt_a, 0);
    check("rst_first_err", fea_a, 0);
    check("rst_busy_b", busy_b, 0);

    // Start on the first edge after reset release; mode 0, clean
    sys_rst = 1'b0;
    run(2'd0, 1'b0, 0, 0);
    check("m0_done_cyc_a", dc_a, 66);
    check("m0_done_cnt_a", dn_a, 1);
    check("m0_busy_len_a", bn_a, 65);
    check("m0_pass_a", pass_a, 1);
    check("m0_err_a", err_cnt_a, 0);
    check("m0_done_cyc_b", dc_b, 67);
    check("m0_busy_len_b", bn_b, 66);
    check("m0_pass_b", pass_b, 1);

    // Checkerboard with one injected error at address 3
    run(2'd2, 1'b1, 0, 0);
    check("inj_done_cyc_a", dc_a, 66);
    check("inj_pass_a", pass_a, 0);
    check("inj_err_a", err_cnt_a, 1);
    check("inj_first_a", fea_a, 3);
    check("inj_done_cyc_b", dc_b, 67);
    check("inj_pass_b", pass_b, 0);
    check("inj_err_b", err_cnt_b, 1);
    check("inj_first_b", fea_b, 3);
    check("inj_mem3_a", dut_a.mem[3], 8'hAB);

    // Inverted address pattern; address 5 holds ~5
    run(2'd1, 1'b0, 0, 0);
    check("m1_done_cyc_b", dc_b, 67);
    check("m1_pass_b", pass_b, 1);
    check("m1_mem5_b", dut_b.mem[5], 8'hFA);
    check("m1_mem5_a", dut_a.mem[5], 8'hFA);
    check("m1_clr_a", clr_a, 0);

    // start pulsed again at cycle 10 is ignored
    run(2'd0, 1'b0, 10, 0);
    check("restart_done_cnt_a", dn_a, 1);
    check("restart_done_cyc_a", dc_a, 66);
    check("restart_done_cnt_b", dn_b, 1);
    check("restart_pass_a", pass_a, 1);

    // Reset at cycle 40 (after the address-3 miscompare was counted) aborts the run
    run(2'd2, 1'b1, 0, 40);
    check("abort_done_cnt_a", dn_a, 0);
    check("abort_done_cnt_b", dn_b, 0);
    check("abort_busy_a", busy_a, 0);
    check("abort_err_a", err_cnt_a, 0);
    check("abort_first_a", fea_a, 0);
    check("abort_pass_a", pass_a, 0);

    // All-ones run after the abort
    run(2'd3, 1'b0, 0, 0);
    check("m3_done_cyc_a", dc_a, 66);
    check("m3_pass_a", pass_a, 1);
    check("m3_err_a", err_cnt_a, 0);
    check("m3_pass_b", pass_b, 1);

    // Back-to-back: failing run then clean run clears the count at WRITE entry
    run(2'd0, 1'b1, 0, 0);
    check("b2b1_err_a", err_cnt_a, 1);
    check("b2b1_first_a", fea_a, 3);
    run(2'd0, 1'b0, 0, 0);
    check("b2b2_clr_a", clr_a, 0);
    check("b2b2_clr_b", clr_b, 0);
    check("b2b2_pass_a", pass_a, 1);
    check("b2b2_err_a", err_cnt_a, 0);
    check("b2b2_pass_b", pass_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
